// File: rtl/aux_input_conditioner.sv
// aux_input_conditioner: per-bit synchroniser and debouncer for the raw board inputs
//   clk        : board clock, rising edge
//   rst        : synchronous active-high reset
//   raw        : asynchronous pin levels (bit 16 = resume, bits 15:0 = switches)
//   level      : debounced stable level per bit
//   rise/fall  : one-cycle pulse per bit when level goes 0->1 / 1->0
//   any_change : OR of all rise and fall bits, aligned with them
module aux_input_conditioner #(
    parameter int InBit  = 17,
    parameter int DebCnt = 1000000,
    parameter int CntBit = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [InBit-1:0] raw,
    output logic [InBit-1:0] level,
    output logic [InBit-1:0] rise,
    output logic [InBit-1:0] fall,
    output logic             any_change
);
    logic [InBit-1:0] sync1, sync2, flip;
    // flip only fires while sync2 differs from level, so level ^ flip lands on sync2
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            level      <= '0;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            level      <= level ^ flip;
            rise       <= flip & sync2;
            fall       <= flip & ~sync2;
            any_change <= |flip;
        end
    end
    for (genvar i = 0; i < InBit; i++) begin : g_bit
        logic [CntBit-1:0] cnt;
        // cnt == 0 is the STABLE state; any agreement with level restarts the run
        assign flip[i] = (sync2[i] != level[i]) && (cnt == CntBit'(DebCnt - 1));
        always_ff @(posedge clk) begin
            cnt <= (rst || sync2[i] == level[i] || flip[i]) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_aux_input_conditioner.sv
// tb_aux_input_conditioner: vector table plus scoreboard check of the debouncer with DebCnt=4
module tb_aux_input_conditioner;
    localparam int InBit = 17;
    localparam int DebCnt = 4;
    localparam int CntBit = 3;
    logic clk = 1'b0;
    logic rst;
    logic [InBit-1:0] raw, level, rise, fall;
    logic any_change;
    int errors = 0;
    int checks = 0;
    int rise2_cnt = 0;
    always #5 clk = ~clk;
    aux_input_conditioner #(.InBit(InBit), .DebCnt(DebCnt), .CntBit(CntBit)) dut (
        .clk(clk), .rst(rst), .raw(raw), .level(level),
        .rise(rise), .fall(fall), .any_change(any_change)
    );
    typedef struct {
        logic             r;
        logic [InBit-1:0] rw;
        logic [InBit-1:0] lv;
        logic [InBit-1:0] ri;
        logic [InBit-1:0] fa;
        logic             an;
    } vec_t;
    vec_t tbl[$];
    vec_t exp_q[$];
    function automatic vec_t mk(input logic r, input logic [InBit-1:0] rw, lv, ri, fa, input logic an);
        vec_t v;
        v.r = r; v.rw = rw; v.lv = lv; v.ri = ri; v.fa = fa; v.an = an;
        return v;
    endfunction
    function automatic void add(input logic r, input logic [InBit-1:0] rw, lv, ri, fa, input logic an);
        tbl.push_back(mk(r, rw, lv, ri, fa, an));
    endfunction
    function automatic void add_hold(input logic [InBit-1:0] rw, lv, input int n);
        for (int k = 0; k < n; k++) add(1'b0, rw, lv, '0, '0, 1'b0);
    endfunction
    // clean step: old level for DebCnt+1 edges, flip with pulses on edge DebCnt+2, then quiet
    function automatic void add_step(input logic [InBit-1:0] rw, old_lv, new_lv, ri, fa);
        add_hold(rw, old_lv, DebCnt + 1);
        add(1'b0, rw, new_lv, ri, fa, 1'b1);
        add_hold(rw, new_lv, 1);
    endfunction
    task automatic chk(input string nm, input int idx, input logic [InBit-1:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        rst = v.r;
        raw = v.rw;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (rise[2] === 1'b1) rise2_cnt++;
        chk("level", idx, level, e.lv);
        chk("rise", idx, rise, e.ri);
        chk("fall", idx, fall, e.fa);
        chk("any_change", idx, {16'b0, any_change}, {16'b0, e.an});
        chk("rise_and_fall", idx, rise & fall, '0);
    endtask
    initial begin
        int b[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        vec_t f[$];
        rst = 1'b1;
        raw = '0;
        add(1'b1, 17'h1FFFF, '0, '0, '0, 1'b0);
        add(1'b1, 17'h1FFFF, '0, '0, '0, 1'b0);
        add_step(17'h1FFFF, '0, 17'h1FFFF, 17'h1FFFF, '0);
        add_step('0, 17'h1FFFF, '0, '0, 17'h1FFFF);
        add_hold('0, '0, 2);
        add_step(17'h00001, '0, 17'h00001, 17'h00001, '0);
        for (int k = 0; k < 3; k++) add(1'b0, 17'h00009, 17'h00001, '0, '0, 1'b0);
        add_hold(17'h00001, 17'h00001, 5);
        for (int k = 0; k < 9; k++) add(1'b0, b[k] != 0 ? 17'h10001 : 17'h00001, 17'h00001, '0, '0, 1'b0);
        add(1'b0, 17'h10001, 17'h00001, '0, '0, 1'b0);
        add(1'b0, 17'h10001, 17'h10001, 17'h10000, '0, 1'b1);
        add_hold(17'h10001, 17'h10001, 3);
        add_step(17'h10421, 17'h10001, 17'h10421, 17'h00420, '0);
        add_step(17'h10001, 17'h10421, 17'h10001, '0, 17'h00420);
        foreach (tbl[i]) apply(tbl[i], i);
        rise2_cnt = 0;
        for (int k = 0; k < 3; k++) f.push_back(mk(1'b0, 17'h10005, 17'h10001, '0, '0, 1'b0));
        f.push_back(mk(1'b1, 17'h10005, '0, '0, '0, 1'b0));
        for (int k = 0; k < DebCnt + 1; k++) f.push_back(mk(1'b0, 17'h10005, '0, '0, '0, 1'b0));
        f.push_back(mk(1'b0, 17'h10005, 17'h10005, 17'h10005, '0, 1'b1));
        for (int k = 0; k < 3; k++) f.push_back(mk(1'b0, 17'h10005, 17'h10005, '0, '0, 1'b0));
        foreach (f[i]) apply(f[i], 1000 + i);
        chk("rise2_pulses", 0, 17'(rise2_cnt), 17'd1);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
